// File: rtl/lfsr_checker.sv
`timescale 1ns/1ps
// lfsr_checker: self-synchronising PRBS receive checker with saturating error/word counters.
// Latency: err_o, locked_o and counter updates appear one cycle after the valid_i sample causing them.
// Backpressure: none; a word is consumed on every cycle with enable_i & valid_i, enable_i=0 freezes state.
//
// Ports:
//   wb_clk_i, wb_rst_ni      : clock, asynchronous active-low reset
//   enable_i, valid_i        : qualify data_i; nothing advances while enable_i is low
//   data_i [WIDTH]           : received PRBS word
//   clr_i                    : synchronous clear of both counters (wins over an increment)
//   locked_o, err_o          : lock status, one-cycle mismatch pulse while locked
//   err_cnt_o, word_cnt_o    : saturating mismatch count and checked-word count
// Option macro: LFSR_CHK_AUTORESYNC_EN -- drop lock after LOSS_THRESH consecutive mismatches.
module lfsr_checker #(
  parameter int unsigned WIDTH       = 9,
  parameter int unsigned TAP         = 4,
  parameter int unsigned LOCK_CNT    = 4,
  parameter int unsigned LOSS_THRESH = 4,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_ni,
  input  logic             enable_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             clr_i,
  output logic             locked_o,
  output logic             err_o,
  output logic [CNT_W-1:0] err_cnt_o,
  output logic [CNT_W-1:0] word_cnt_o
);

  localparam logic [1:0] ST_HUNT   = 2'd0;
  localparam logic [1:0] ST_SYNC   = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  localparam logic [3:0]       ONE4    = 4'd1;
  localparam logic [3:0]       LOCK_N  = LOCK_CNT[3:0];
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Thresholds are held in 4-bit counters; an out-of-range value shows up as
  // this named block in the elaborated hierarchy.
  if (LOCK_CNT == 0 || LOCK_CNT > 15 || LOSS_THRESH == 0 || LOSS_THRESH > 15) begin : g_threshold_out_of_range
  end

  function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] s);
    return {s[WIDTH-2:0], s[WIDTH-1] ^ s[TAP]};
  endfunction

  logic [1:0]       r_state;
  logic             r_locked;
  logic [WIDTH-1:0] r_prev;
  logic [WIDTH-1:0] r_exp;
  logic [3:0]       r_match;
  logic             r_err;
  logic [CNT_W-1:0] r_err_cnt;
  logic [CNT_W-1:0] r_word_cnt;
`ifdef LFSR_CHK_AUTORESYNC_EN
  localparam logic [3:0] LOSS_N = LOSS_THRESH[3:0];
  logic [3:0]       r_bad;
`endif

  logic w_take;
  logic w_zero;
  logic w_sync_hit;
  logic w_lock_hit;
  logic w_chk;
  logic w_mis;

  assign w_take     = enable_i & valid_i;
  assign w_zero     = (data_i == '0);
  assign w_sync_hit = (data_i == lfsr_next(r_prev));
  // r_exp always holds the prediction for the word currently on data_i.
  assign w_lock_hit = (data_i == r_exp);
  assign w_chk      = w_take & (r_state == ST_LOCKED);
  assign w_mis      = w_chk & ~w_lock_hit;

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_state  <= ST_HUNT;
      r_locked <= 1'b0;
      r_prev   <= '0;
      r_exp    <= '0;
      r_match  <= '0;
`ifdef LFSR_CHK_AUTORESYNC_EN
      r_bad    <= '0;
`endif
    end else if (w_take) begin
      case (r_state)
        ST_HUNT: begin
          if (!w_zero) begin
            r_prev  <= data_i;
            r_match <= '0;
            r_state <= ST_SYNC;
          end
        end
        ST_SYNC: begin
          // Zero is checked first: it is never a legal PRBS word.
          if (w_zero) begin
            r_state <= ST_HUNT;
          end else if (w_sync_hit) begin
            r_prev  <= data_i;
            r_match <= r_match + ONE4;
            if (r_match + ONE4 == LOCK_N) begin
              r_state  <= ST_LOCKED;
              r_locked <= 1'b1;
              r_exp    <= lfsr_next(data_i);
            end
          end else begin
            r_prev  <= data_i;
            r_match <= '0;
          end
        end
        ST_LOCKED: begin
          // Free-running prediction: never reseeded from the received data.
          r_exp <= lfsr_next(r_exp);
`ifdef LFSR_CHK_AUTORESYNC_EN
          if (w_lock_hit) begin
            r_bad <= '0;
          end else if (r_bad + ONE4 == LOSS_N) begin
            r_state  <= ST_HUNT;
            r_locked <= 1'b0;
            r_bad    <= '0;
            r_match  <= '0;
          end else begin
            r_bad <= r_bad + ONE4;
          end
`endif
        end
        default: begin
          r_state  <= ST_HUNT;
          r_locked <= 1'b0;
        end
      endcase
    end
  end

  // err_o is a pulse, so it drops on any cycle without a checked mismatch,
  // including disabled cycles. clr_i acts regardless of enable_i.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_err      <= 1'b0;
      r_err_cnt  <= '0;
      r_word_cnt <= '0;
    end else begin
      r_err <= w_mis;
      if (clr_i) begin
        r_err_cnt  <= '0;
        r_word_cnt <= '0;
      end else begin
        if (w_chk && r_word_cnt != CNT_MAX) r_word_cnt <= r_word_cnt + CNT_ONE;
        if (w_mis && r_err_cnt != CNT_MAX)  r_err_cnt  <= r_err_cnt + CNT_ONE;
      end
    end
  end

  assign locked_o   = r_locked;
  assign err_o      = r_err;
  assign err_cnt_o  = r_err_cnt;
  assign word_cnt_o = r_word_cnt;

endmodule

// File: tb/tb_lfsr_checker.sv
`timescale 1ns/1ps
module tb_lfsr_checker;

  localparam int LOCK = 4;
  localparam int LOSS = 4;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  localparam int M_HUNT   = 0;
  localparam int M_SYNC   = 1;
  localparam int M_LOCKED = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          tb_en = 1'b0;
  logic          tb_vld = 1'b0;
  logic [8:0]    tb_dat = '0;
  logic          tb_clr = 1'b0;
  logic          locked;
  logic          err;
  logic [CW-1:0] err_cnt;
  logic [CW-1:0] word_cnt;

  always #5 clk = ~clk;

  lfsr_checker #(.WIDTH(9), .TAP(4), .LOCK_CNT(LOCK), .LOSS_THRESH(LOSS), .CNT_W(CW)) dut (
    .wb_clk_i  (clk),
    .wb_rst_ni (rst_n),
    .enable_i  (tb_en),
    .valid_i   (tb_vld),
    .data_i    (tb_dat),
    .clr_i     (tb_clr),
    .locked_o  (locked),
    .err_o     (err),
    .err_cnt_o (err_cnt),
    .word_cnt_o(word_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input int act, input int expv);
    n_tests++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // PRBS9 step written as plain integer arithmetic on x^9+x^5+1.
  function automatic int nxt(input int s);
    return ((s << 1) & 'h1FF) | (((s >> 8) ^ (s >> 4)) & 1);
  endfunction

  int m_mode, m_prev, m_exp, m_match, m_bad, m_errc, m_wordc;
  bit m_err;

  task automatic model_reset();
    m_mode = M_HUNT; m_prev = 0; m_exp = 0; m_match = 0; m_bad = 0;
    m_errc = 0; m_wordc = 0; m_err = 0;
  endtask

  task automatic model_step(input bit en, input bit vld, input int d, input bit clr);
    bit e;
    bit c;
    e = 0;
    c = 0;
    if (en && vld) begin
      if (m_mode == M_LOCKED) begin
        c = 1;
        if (d == m_exp) m_bad = 0;
        else begin e = 1; m_bad++; end
        m_exp = nxt(m_exp);
`ifdef LFSR_CHK_AUTORESYNC_EN
        if (m_bad >= LOSS) begin m_mode = M_HUNT; m_bad = 0; m_match = 0; end
`endif
      end else if (m_mode == M_HUNT) begin
        if (d != 0) begin m_prev = d; m_match = 0; m_mode = M_SYNC; end
      end else begin
        if (d == 0) m_mode = M_HUNT;
        else if (d == nxt(m_prev)) begin
          m_match++;
          m_prev = d;
          if (m_match == LOCK) begin m_mode = M_LOCKED; m_exp = nxt(d); end
        end else begin m_prev = d; m_match = 0; end
      end
    end
    if (clr) begin
      m_errc = 0; m_wordc = 0;
    end else begin
      if (c && m_wordc < CMAX) m_wordc++;
      if (e && m_errc < CMAX)  m_errc++;
    end
    m_err = e;
  endtask

  // ---------------- scoreboard ----------------
  typedef struct {
    bit locked;
    bit err;
    int errc;
    int wordc;
  } exp_t;

  exp_t q[$];

  task automatic cyc(input bit en, input bit vld, input int d, input bit clr);
    exp_t e;
    @(negedge clk);
    tb_en  = en;
    tb_vld = vld;
    tb_dat = 9'(d);
    tb_clr = clr;
    model_step(en, vld, d, clr);
    e.locked = (m_mode == M_LOCKED);
    e.err    = m_err;
    e.errc   = m_errc;
    e.wordc  = m_wordc;
    q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("mon_locked", int'(locked), int'(e.locked));
        chk("mon_err", int'(err), int'(e.err));
        chk("mon_err_cnt", int'(err_cnt), e.errc);
        chk("mon_word_cnt", int'(word_cnt), e.wordc);
      end
    end
  end

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_locked"}, int'(locked), 0);
    chk({tag, "_err"}, int'(err), 0);
    chk({tag, "_err_cnt"}, int'(err_cnt), 0);
    chk({tag, "_word_cnt"}, int'(word_cnt), 0);
  endtask

  task automatic lock_seq(input int seed, input int n);
    int w;
    w = seed;
    for (int i = 0; i < n; i++) begin
      cyc(1, 1, w, 0);
      w = nxt(w);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, int'($urandom_range(0, 511)), 0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int w, r, seed;
    model_reset();
    #1;
    chk_reset_outputs("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Zero word in HUNT, then the canonical lock sequence.
    cyc(1, 1, 0, 0);
    lock_seq('h001, 4);
    settle();
    chk("not_locked_after_4", int'(locked), 0);
    lock_seq('h010, 1);
    settle();
    chk("locked_after_010", int'(locked), 1);
    chk("err_cnt_at_lock", int'(err_cnt), 0);
    chk("word_cnt_at_lock", int'(word_cnt), 0);

    // Single bit error followed by correct successors.
    cyc(1, 1, m_exp ^ 1, 0);
    settle();
    chk("single_err_pulse", int'(err), 1);
    for (int i = 0; i < 5; i++) cyc(1, 1, m_exp, 0);
    settle();
    chk("single_err_cnt", int'(err_cnt), 1);
    chk("single_err_locked", int'(locked), 1);

    // Valid gaps of 0..5 cycles.
    for (int i = 0; i < 40; i++) begin
      idle(int'($urandom_range(0, 5)));
      cyc(1, 1, m_exp, 0);
    end
    settle();
    chk("gaps_err_cnt", int'(err_cnt), 1);

    // enable_i low while valid_i toggles with random data.
    for (int i = 0; i < 10; i++) cyc(0, i[0], int'($urandom_range(0, 511)), 0);
    cyc(1, 1, m_exp, 0);

    // Clear in the same cycle as a mismatch.
    cyc(1, 1, m_exp ^ 'h100, 1);
    settle();
    chk("clr_err_pulse", int'(err), 1);
    chk("clr_err_cnt", int'(err_cnt), 0);

    // Keep the garbage word from coinciding with the prediction.
    while (m_exp == 'h155 || nxt(m_exp) == 'h155 || nxt(nxt(m_exp)) == 'h155 ||
           nxt(nxt(nxt(m_exp))) == 'h155)
      cyc(1, 1, m_exp, 0);
    for (int i = 0; i < 3; i++) cyc(1, 1, 'h155, 0);
    settle();
    chk("garbage3_locked", int'(locked), 1);
    cyc(1, 1, 'h155, 0);
    settle();
    chk("garbage_err_cnt", int'(err_cnt), 4);
`ifdef LFSR_CHK_AUTORESYNC_EN
    chk("garbage_lock_lost", int'(locked), 0);
    lock_seq('h0AA, 5);
    settle();
    chk("relock_0aa", int'(locked), 1);
`else
    chk("garbage_lock_held", int'(locked), 1);
    lock_seq('h0AA, 5);
    settle();
    chk("still_locked_0aa", int'(locked), 1);
`endif

    // Saturation: interleave errors with good words so lock is never lost.
    for (int i = 0; i < 20; i++) begin
      cyc(1, 1, m_exp ^ int'($urandom_range(1, 511)), 0);
      cyc(1, 1, m_exp, 0);
    end
    settle();
    chk("err_cnt_saturated", int'(err_cnt), CMAX);
    chk("word_cnt_saturated", int'(word_cnt), CMAX);

    // Mixed random traffic checked by the model.
    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 10)      cyc(1, 0, int'($urandom_range(0, 511)), 0);
      else if (r < 15) cyc(0, 1, int'($urandom_range(0, 511)), 0);
      else if (r < 18) cyc(1, 1, 0, 0);
      else if (r < 28) cyc(1, 1, int'($urandom_range(1, 511)), 0);
      else if (r < 32) cyc(1, 1, (m_mode == M_LOCKED) ? m_exp : nxt(m_prev), 1);
      else if (m_mode == M_LOCKED) cyc(1, 1, m_exp, 0);
      else if (m_mode == M_SYNC)   cyc(1, 1, nxt(m_prev), 0);
      else cyc(1, 1, int'($urandom_range(1, 511)), 0);
    end

    // Asynchronous reset mid-stream, then re-hunt from a random seed.
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    q.delete();
    model_reset();
    chk_reset_outputs("midreset");
    tb_vld = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seed = int'($urandom_range(1, 511));
    lock_seq(seed, 4);
    settle();
    chk("rehunt_not_locked", int'(locked), 0);
    w = seed;
    for (int i = 0; i < 4; i++) w = nxt(w);
    lock_seq(w, 1);
    settle();
    chk("rehunt_locked", int'(locked), 1);

    cyc(1, 0, 0, 0);
    settle();
    chk("queue_drained", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lfsr_checker.md
# lfsr_checker

Receive-side checker for the LFSR pattern generator driven onto the user I/O pads. It samples parallel PRBS words from the pads and self-synchronises a local LFSR to the incoming stream. Once locked, it flags every word that differs from the predicted sequence and keeps saturating error and word counters for logic-analyzer readback. It sits in `user_project_wrapper` beside the generator and is fed by a loopback or an external board.

## Interface
Parameters:
- `WIDTH`, 9: word width, equal to the LFSR length.
- `TAP`, 4: second feedback tap index. Feedback = `s[WIDTH-1] ^ s[TAP]` (PRBS9: x^9+x^5+1).
- `LOCK_CNT`, 4: consecutive correct predictions required to lock (1..15).
- `LOSS_THRESH`, 4: consecutive mismatches that drop lock (1..15).
- `CNT_W`, 16: width of the error and word counters.

Ports:
- `wb_clk_i`, in, 1: the only clock; all logic is on its rising edge.
- `wb_rst_ni`, in, 1: asynchronous active-low reset. Assertion is asynchronous; deassertion is synchronous to `wb_clk_i`.
- `enable_i`, in, 1: when low, `valid_i` is ignored and all state is held.
- `valid_i`, in, 1: `data_i` holds a new word this cycle.
- `data_i`, in, WIDTH: received word.
- `clr_i`, in, 1: synchronous clear of both counters.
- `locked_o`, out, 1: checker is in LOCKED.
- `err_o`, out, 1: one-cycle pulse for each mismatched word while LOCKED.
- `err_cnt_o`, out, CNT_W: saturating mismatch count.
- `word_cnt_o`, out, CNT_W: saturating count of words checked while LOCKED.

## Operation
- Step function: `next(s) = {s[WIDTH-2:0], s[WIDTH-1]^s[TAP]}`. The generator advances one step per word.
- An all-zero word is never legal.
- **HUNT** (reset state):
  - On a valid, nonzero word: `prev <= data`, `match <= 0`, go to SYNC.
  - On a zero word: stay in HUNT.
- **SYNC**:
  - On a valid word equal to `next(prev)`: `match++` and `prev <= data`.
  - When `match` reaches LOCK_CNT: go to LOCKED and set `exp <= next(data)`.
  - On a mismatch with nonzero data: reseed with `prev <= data`, `match <= 0`.
  - On a zero word: go to HUNT.
  - No errors are counted in HUNT or SYNC.
- **LOCKED**: on every valid word, `exp <= next(exp)`. The local LFSR is never reseeded from the data.
  - On a match: `bad <= 0` and `word_cnt++`.
  - On a mismatch (a zero word counts as a mismatch): `err_o` pulses, `err_cnt++`, `word_cnt++`, `bad++`.
- Both counters saturate at all-ones and never wrap.
- `clr_i` zeroes both counters. If `clr_i` arrives in the same cycle as an increment, the clear wins. `clr_i` does not change the FSM state.
- Reset values: state = HUNT; `prev`, `exp`, `match`, `bad` = 0; `locked_o` = 0; `err_o` = 0; `err_cnt_o` = 0; `word_cnt_o` = 0.
- Reset asserted mid-stream aborts immediately, and the checker must re-hunt after reset.

## Timing
- All outputs are registered.
- `err_o` and the counter updates appear one cycle after the `valid_i` sample that caused them.
- `locked_o` rises one cycle after the LOCK_CNT-th consecutive match. The earliest lock is therefore 1 + LOCK_CNT valid words after leaving reset.
- Lock loss (see Configuration): `locked_o` falls one cycle after the LOSS_THRESH-th consecutive mismatch. That word is itself counted as an error.
- Gaps in `valid_i` are allowed with any spacing. The prediction advances only on valid words.

## Configuration
- Macro: `LFSR_CHK_AUTORESYNC_EN`.
- Defined:
  - In LOCKED, when `bad` reaches LOSS_THRESH, go to HUNT and clear `bad` and `match`.
  - The next nonzero word reseeds the checker. The counters are kept.
- Undefined:
  - LOCKED is exited only by reset. `bad` is not implemented.
  - Any number of consecutive errors keeps `locked_o` = 1 and keeps counting.

## Test plan
- **Reset and lock**: reset, then valid words `001, 002, 004, 008, 010` → `locked_o` = 1 one cycle after word `010`. `err_cnt_o` = 0. `word_cnt_o` = 0 at lock.
- **Single bit error**: after lock, feed the correct stream but send `021^001` = `020` in place of `021`, then continue with the correct successors → exactly one `err_o` pulse, `err_cnt_o` = 1, lock held, and no further errors.
- **Resync** (`LFSR_CHK_AUTORESYNC_EN` on): after lock, send 4 garbage words `155`, then a fresh valid sequence seeded at `0AA` → `locked_o` falls after the 4th bad word, `err_cnt_o` = 4, and the checker re-locks after 5 good words.
- **Resync disabled** (macro off): same stimulus → `locked_o` stays 1 and `err_cnt_o` keeps incrementing on every mismatch.
- **Saturation and clear**: with `CNT_W` = 4, inject 20 errors → `err_cnt_o` = `F`. Assert `clr_i` in the same cycle as a mismatch → `err_cnt_o` = 0 on the next cycle, while the `err_o` pulse still occurs.
- **Zero word, gaps and enable**: a `000` word in HUNT keeps the checker in HUNT. `valid_i` gaps of 0-5 cycles do not cause errors. `enable_i` = 0 while `valid_i` toggles leaves all outputs unchanged.
